clk_rate_gen: RTL and testbench
===============================

# clk_rate_gen

Rate generator that produces the fast, medium and slow clock-rate signals consumed by the board's rate-select logic, plus a switch-selected tick for downstream counters/displays. All rates are derived from the single system clock by independent free-running dividers. The selected rate changes only on a boundary of the currently selected period, so downstream logic never sees a truncated period or a double tick.

## Interface
- DIV_FAST, default 4: system cycles per fast period; even, ≥2.
- DIV_MEDIUM, default 16: system cycles per medium period; even, ≥2.
- DIV_SLOW, default 64: system cycles per slow period; even, ≥2.
- CNT_W, default 8: divider counter width; must satisfy 2^CNT_W ≥ max DIV.
- DEBOUNCE_CYC, default 8: stable cycles required when debounce is compiled in; ≥1.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw2, sw1  input  1 each  asynchronous rate-select switches.
- clkFast, clkMedium, clkSlow  output  1 each  50% square waves; high while divider count < DIV/2.
- tickFast, tickMedium, tickSlow  output  1 each  one-cycle strobes, high while divider count == DIV-1.
- tickSel  output  1  strobe of the currently selected rate.
- rateSel  output  2  current rate: 2'b00 slow, 2'b10 medium, 2'b11 fast.
- switching  output  1  high while a rate change is pending.

## Operation
- Three counters, each runs 0..DIV-1 and wraps to 0. They are never cleared except by reset, so the fixed-rate outputs are unaffected by switching.
- Switch input path: 2-flop synchronizer on {sw2,sw1}. The synchronized value becomes the accepted code directly, or after debounce (see Configuration).
- Code map for the accepted code: 00 → slow, 10 → medium, 11 → fast, 01 → hold.
- Under hold, the target does not change and any pending target is kept.
- FSM states:
  - RUN: switching=0. If the accepted code maps to a rate ≠ rateSel, latch it as the target and go to PEND.
  - PEND: switching=1. tickSel still follows the old rate. In the cycle the old rate's tick is high, that tick is emitted on tickSel; on the next edge, rateSel ← target and the FSM returns to RUN.
  - PEND, accepted code changes to another valid rate: the target updates and the FSM stays in PEND.
  - PEND, accepted code changes back to the current rateSel: the change is cancelled and the FSM goes to RUN in the next cycle.
- tickSel = tick of the rate in rateSel, decoded combinationally from the registered state. At most one tickSel pulse occurs per old-period boundary. If old and new ticks coincide in the switch cycle, tickSel gives one pulse only.

## Timing
- Reset values:
  - all counters 0
  - clkFast, clkMedium, clkSlow = 1 (count 0 < DIV/2)
  - all ticks 0
  - rateSel = 2'b00
  - switching = 0
  - FSM in RUN
  - synchronizer and debounce registers 0
- After rst_n deasserts, each tick first goes high in cycle DIV-1 (cycles numbered from 0 at the first edge). It then repeats every DIV cycles.
- Switch to FSM latency, without debounce: a switch change is visible to the FSM 2 cycles after it is sampled. PEND is entered on the following edge.
- Switch completion: rateSel updates on the edge after the old rate's tick, so the worst-case wait is DIV_old cycles after entering PEND.
- Reset asserted mid-PEND: the FSM returns immediately to RUN with slow selected. The pending target is discarded.

## Configuration
- CLK_RATE_DEBOUNCE_EN:
  - Defined: the synchronized code must hold the same value for DEBOUNCE_CYC consecutive cycles before it becomes the accepted code. Any change restarts the stability count.
  - Undefined: the synchronized code is accepted every cycle. The debounce counter and DEBOUNCE_CYC are unused.

## Test plan
- Reset release with default parameters → tickFast high at cycles 3, 7, 11; tickMedium at 15; tickSlow at 63; clkFast pattern 1,1,0,0 repeating; rateSel=00.
- From slow, set sw={1,1} at cycle 10 → switching=1 until the cycle-63 slowTick; tickSel pulses at 63; rateSel=11 at cycle 64; next tickSel at 67.
- In RUN fast, set sw={0,1} → rateSel stays 11, switching stays 0, tickSel continues every 4 cycles.
- In PEND from slow toward medium, return sw={0,0} before the slow boundary → switching drops, rateSel stays 00, no extra tickSel.
- Assert rst_n low mid-PEND for one cycle → all outputs take their reset values immediately; counters restart from 0.
- With CLK_RATE_DEBOUNCE_EN, toggle sw1 with a 3-cycle glitch (DEBOUNCE_CYC=8) → no PEND entry; hold it for 8 cycles → PEND is entered.

Source files
------------

// File: rtl/clk_rate_gen.sv
// clk_rate_gen: free-running fast/medium/slow dividers plus a switch-selected tick whose
// rate changes only on a boundary of the old period. Optional debounce: CLK_RATE_DEBOUNCE_EN.
module clk_rate_gen #(
  parameter int DIV_FAST     = 4,
  parameter int DIV_MEDIUM   = 16,
  parameter int DIV_SLOW     = 64,
  parameter int CNT_W        = 8,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw2,
  input  logic       sw1,
  output logic       clkFast,
  output logic       clkMedium,
  output logic       clkSlow,
  output logic       tickFast,
  output logic       tickMedium,
  output logic       tickSlow,
  output logic       tickSel,
  output logic [1:0] rateSel,
  output logic       switching
);

  localparam int NR = 3;  // divider index: 0 slow, 1 medium, 2 fast

  typedef enum logic {RUN, PEND} state_t;

  logic [NR-1:0] tick;
  logic [NR-1:0] half;
  logic [1:0]    sync1_reg;
  logic [1:0]    sync2_reg;
  logic [1:0]    code;
  logic          code_valid;
  logic [1:0]    next_target;
  logic          tick_old;
  logic [1:0]    rate_sel_reg;
  logic [1:0]    target_reg;
  state_t        state_reg;

  if (DEBOUNCE_CYC < 1 || DIV_FAST < 2 || DIV_MEDIUM < 2 || DIV_SLOW < 2 ||
      (DIV_FAST % 2) != 0 || (DIV_MEDIUM % 2) != 0 || (DIV_SLOW % 2) != 0) begin : g_bad_cfg
    $error("clk_rate_gen: illegal divider or debounce parameter");
  end

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_div
      localparam int D = (gi == 0) ? DIV_SLOW : (gi == 1) ? DIV_MEDIUM : DIV_FAST;
      localparam logic [CNT_W-1:0] LAST  = CNT_W'(D - 1);
      localparam logic [CNT_W-1:0] HALFV = CNT_W'(D / 2);

      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign tick[gi] = (cnt_reg == LAST);
      assign half[gi] = (cnt_reg < HALFV);
    end
  endgenerate

  assign clkSlow    = half[0];
  assign clkMedium  = half[1];
  assign clkFast    = half[2];
  assign tickSlow   = tick[0];
  assign tickMedium = tick[1];
  assign tickFast   = tick[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= {sw2, sw1};
      sync2_reg <= sync1_reg;
    end
  end

`ifdef CLK_RATE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic [DB_W-1:0] db_cnt_reg;
  logic [1:0]      cand_reg;
  logic [1:0]      acc_reg;

  // db_cnt_reg counts consecutive cycles the candidate has been seen, saturating at DEBOUNCE_CYC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_reg <= '0;
      cand_reg   <= 2'b00;
      acc_reg    <= 2'b00;
    end else if (sync2_reg != cand_reg) begin
      cand_reg   <= sync2_reg;
      db_cnt_reg <= DB_W'(1);
      if (DEBOUNCE_CYC == 1) acc_reg <= sync2_reg;
    end else if (db_cnt_reg < DB_W'(DEBOUNCE_CYC)) begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
      if (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) acc_reg <= cand_reg;
    end
  end

  assign code = acc_reg;
`else
  assign code = sync2_reg;
`endif

  // code 01 means hold: neither requests a change nor cancels a pending one
  assign code_valid  = (code != 2'b01);
  assign next_target = code_valid ? code : target_reg;

  always_comb begin
    tick_old = tick[0];
    case (rate_sel_reg)
      2'b11:   tick_old = tick[2];
      2'b10:   tick_old = tick[1];
      default: tick_old = tick[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      rate_sel_reg <= 2'b00;
      target_reg   <= 2'b00;
    end else begin
      case (state_reg)
        RUN: begin
          if (code_valid && code != rate_sel_reg) begin
            target_reg <= code;
            state_reg  <= PEND;
          end
        end
        PEND: begin
          if (code_valid && code == rate_sel_reg) begin
            state_reg <= RUN;
          end else if (tick_old) begin
            rate_sel_reg <= next_target;
            state_reg    <= RUN;
          end else begin
            target_reg <= next_target;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  // tickSel follows the old rate until the edge after its boundary tick
  assign tickSel   = tick_old;
  assign rateSel   = rate_sel_reg;
  assign switching = (state_reg == PEND);

endmodule

// File: tb/tb_clk_rate_gen.sv
// tb_clk_rate_gen: random switch segments against a cycle-count reference model; expected
// output vectors are queued per cycle and checked by an independent monitor.
module tb_clk_rate_gen;

  localparam int DF = 4;
  localparam int DM = 16;
  localparam int DS = 64;

  typedef logic [9:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw2 = 1'b0;
  logic       sw1 = 1'b0;
  logic       clkFast, clkMedium, clkSlow;
  logic       tickFast, tickMedium, tickSlow, tickSel;
  logic [1:0] rateSel;
  logic       switching;
  vec_t       got;

  vec_t       exp_q[$];
  logic [1:0] hist[$];
  int         n_vec = 0;
  int         n_bad = 0;
  bit         running = 1'b0;

  int         e;
  logic [1:0] rate;
  logic [1:0] target;
  bit         pend;

  localparam vec_t RESET_VEC = 10'b1110000000;

  clk_rate_gen #(
    .DIV_FAST(DF), .DIV_MEDIUM(DM), .DIV_SLOW(DS), .CNT_W(8), .DEBOUNCE_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw2(sw2), .sw1(sw1),
    .clkFast(clkFast), .clkMedium(clkMedium), .clkSlow(clkSlow),
    .tickFast(tickFast), .tickMedium(tickMedium), .tickSlow(tickSlow),
    .tickSel(tickSel), .rateSel(rateSel), .switching(switching)
  );

  assign got = {clkFast, clkMedium, clkSlow, tickFast, tickMedium, tickSlow,
                tickSel, rateSel, switching};

  always #5 clk = ~clk;

  function automatic int div_of(input logic [1:0] r);
    return (r == 2'b11) ? DF : (r == 2'b10) ? DM : DS;
  endfunction

  // Outputs in cycle c: each divider is simply c mod DIV
  function automatic vec_t expect_at(input int c, input logic [1:0] r, input bit p);
    int d;
    d = div_of(r);
    return {(c % DF) < DF / 2, (c % DM) < DM / 2, (c % DS) < DS / 2,
            (c % DF) == DF - 1, (c % DM) == DM - 1, (c % DS) == DS - 1,
            (c % d) == d - 1, r, p};
  endfunction

  task automatic model_reset();
    e = 0;
    rate = 2'b00;
    target = 2'b00;
    pend = 1'b0;
    hist.delete();
    hist.push_back(2'b00);
  endtask

  // Advance the model across one clock edge; the switch code seen is the one sampled two edges earlier
  task automatic step();
    logic [1:0] code;
    bit         valid;
    bit         tick_old;
    code     = (e >= 1) ? hist[e-1] : 2'b00;
    valid    = (code != 2'b01);
    tick_old = ((e % div_of(rate)) == div_of(rate) - 1);
    if (!pend) begin
      if (valid && code != rate) begin
        pend = 1'b1;
        target = code;
      end
    end else if (valid && code == rate) begin
      pend = 1'b0;
    end else begin
      if (valid) target = code;
      if (tick_old) begin
        rate = target;
        pend = 1'b0;
      end
    end
    hist.push_back({sw2, sw1});
    e++;
    exp_q.push_back(expect_at(e, rate, pend));
    running = 1'b1;
  endtask

  task automatic hold(input logic [1:0] c, input int n);
    $display("segment: sw=%b for %0d cycles from cycle %0d (rateSel model %b)", c, n, e, rate);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      step();
      if (i == 0) {sw2, sw1} = c;
    end
  endtask

  task automatic check_reset(input string tag);
    n_vec++;
    if (got !== RESET_VEC) begin
      n_bad++;
      $display("FAIL %s: outputs=%b required=%b", tag, got, RESET_VEC);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    running = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(posedge clk);
    #1;
    check_reset("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("reset released, switching model pend was discarded");
  endtask

  always @(negedge clk) begin : monitor
    vec_t x;
    if (running) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL underflow: no expected vector at time %0t, outputs=%b", $time, got);
      end else begin
        x = exp_q.pop_front();
        if (got !== x) begin
          n_bad++;
          $display("FAIL cycle_%0d: outputs=%b required=%b (clkF clkM clkS tF tM tS tSel rate sw)",
                   e, got, x);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    {sw2, sw1} = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("initial_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    hold(2'b00, 9);     // cycles 1..9 in slow
    hold(2'b11, 90);    // change in cycle 10, completes at the slow boundary
    hold(2'b01, 20);    // hold code: stays fast
    hold(2'b00, 70);    // back to slow
    hold(2'b10, 5);     // start toward medium
    hold(2'b00, 40);    // cancel before completing (unless a boundary intervenes)

    for (int k = 0; k < 40; k++) begin
      hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 120)));
    end

    hold(2'b00, 70);
    hold(2'b11, 5);     // pending toward fast
    mid_reset();

    for (int k = 0; k < 30; k++) begin
      hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 120)));
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
